// File: rtl/sram_device_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM device responder:
//   - control-pin encodings {ce_n, oe_n, we_n, lb_n, ub_n}
//   - responder FSM state enum
//   - decoded pin mode enum and the decode function
// -----------------------------------------------------------------------------
package sram_pkg;

  // Control pin bundles, ordered {ce_n, oe_n, we_n, lb_n, ub_n}
  localparam logic [4:0] CTRL_IDLE  = 5'b11111;
  localparam logic [4:0] CTRL_READ  = 5'b00100;
  localparam logic [4:0] CTRL_WRITE = 5'b01000;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_READ_ACCESS  = 3'd1,
    ST_READ_DRIVE   = 3'd2,
    ST_READ_HOLD    = 3'd3,
    ST_WRITE_ACTIVE = 3'd4
  } resp_state_e;

  typedef enum logic [1:0] {
    MODE_DESELECT = 2'd0,
    MODE_READ     = 2'd1,
    MODE_WRITE    = 2'd2
  } pin_mode_e;

  // Write has priority over read; oe_n is ignored while we_n is low.
  function automatic pin_mode_e decode_mode(input logic ce_n,
                                            input logic oe_n,
                                            input logic we_n);
    pin_mode_e m;
    if (!ce_n && !we_n) begin
      m = MODE_WRITE;
    end else if (!ce_n && !oe_n) begin
      m = MODE_READ;
    end else begin
      m = MODE_DESELECT;
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// -----------------------------------------------------------------------------
// sram_byte_array
// Single-port 2**DEPTH_LOG2 x 16 synchronous memory with per-byte write
// enables. A write takes priority over a read on the same cycle; read data is
// registered and holds its value until the next read.
// Ports:
//   clk      clock
//   addr_i   word address
//   rd_en_i  load rdata_o from mem[addr_i] at the next edge
//   wr_en_i  write wdata_i to mem[addr_i] under be_i
//   be_i     byte enables, active high, [1]=upper, [0]=lower
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module sram_byte_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [1:0]            be_i,
  input  logic [15:0]           wdata_i,
  output logic [15:0]           rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  // Storage array: byte-laned write or registered read.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (be_i[0]) begin
        mem_q[addr_i][7:0] <= wdata_i[7:0];
      end
      if (be_i[1]) begin
        mem_q[addr_i][15:8] <= wdata_i[15:8];
      end
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_device_responder.sv
// -----------------------------------------------------------------------------
// sram_device_responder
// Cycle-counted model of a 256K x 16 asynchronous SRAM as seen from the
// controller's pins. Pins are sampled on clk; reads are served after
// ACCESS_CYCLES, held for HOLD_CYCLES after deselect, and writes are committed
// on release if the pulse was long enough. Short or address-disturbed writes
// set a sticky violation flag.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   addr               word address (upper bits above DEPTH_LOG2 alias)
//   dq                 bidirectional data, driven only while serving a read
//   ce_n/oe_n/we_n     chip / output / write enable, active low
//   lb_n/ub_n          byte lane enables, active low
//   read_busy          a read is in access, drive or hold
//   write_busy         a write pulse is in progress
//   write_violation    sticky short/aborted write flag
//   read_count         reads that reached the drive phase (wraps)
//   write_count        committed writes (wraps)
// -----------------------------------------------------------------------------
module sram_device_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W             = 18,
  parameter int DEPTH_LOG2         = 12,
  parameter int ACCESS_CYCLES      = 10,
  parameter int HOLD_CYCLES        = 2,
  parameter int WRITE_PULSE_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [15:0]       dq,
  input  logic              ce_n,
  input  logic              oe_n,
  input  logic              we_n,
  input  logic              lb_n,
  input  logic              ub_n,
  output logic              read_busy,
  output logic              write_busy,
  output logic              write_violation,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count
);

  localparam logic [7:0] ACC_LIM  = 8'(ACCESS_CYCLES);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);
  localparam logic [7:0] WP_LIM   = 8'(WRITE_PULSE_CYCLES);

  resp_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              lb_n_q, lb_n_d;
  logic              ub_n_q, ub_n_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              viol_q, viol_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              rd_busy_q, wr_busy_q;

  pin_mode_e         mode_s;
  logic              addr_chg_s;
  logic [7:0]        cnt_inc_s;
  logic              mem_rd_en_s, mem_wr_en_s;
  logic [15:0]       rdata_s;
  logic              drive_s;

  assign mode_s     = decode_mode(ce_n, oe_n, we_n);
  assign addr_chg_s = (addr != addr_q);
  assign cnt_inc_s  = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);

  // Next-state and datapath control for the responder FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    lb_n_d      = lb_n_q;
    ub_n_d      = ub_n_q;
    wdata_d     = wdata_q;
    viol_d      = viol_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    mem_rd_en_s = 1'b0;
    mem_wr_en_s = 1'b0;

    // A write pulse from any non-write state (re)starts a write; from
    // WRITE_ACTIVE only an address change restarts it, and that is a
    // violation because the pending write is dropped.
    if ((mode_s == MODE_WRITE) &&
        ((state_q != ST_WRITE_ACTIVE) || addr_chg_s)) begin
      if (state_q == ST_WRITE_ACTIVE) begin
        viol_d = 1'b1;
      end else begin
        viol_d = viol_q;
      end
      state_d = ST_WRITE_ACTIVE;
      addr_d  = addr;
      lb_n_d  = lb_n;
      ub_n_d  = ub_n;
      wdata_d = dq;
      cnt_d   = 8'd1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mode_s == MODE_READ) begin
            state_d = ST_READ_ACCESS;
            addr_d  = addr;
            cnt_d   = 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_READ_ACCESS: begin
          if (mode_s == MODE_DESELECT) begin
            state_d = ST_IDLE;
          end else if (addr_chg_s) begin
            addr_d = addr;
            cnt_d  = 8'd1;
          end else if (cnt_q >= ACC_LIM) begin
            // Array fetch rides on this edge so data is ready in DRIVE.
            state_d     = ST_READ_DRIVE;
            mem_rd_en_s = 1'b1;
            rd_cnt_d    = rd_cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end

        ST_READ_DRIVE: begin
          if (mode_s == MODE_DESELECT) begin
            if (HOLD_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_READ_HOLD;
              cnt_d   = 8'd1;
            end
          end else if (addr_chg_s) begin
            state_d = ST_READ_ACCESS;
            addr_d  = addr;
            cnt_d   = 8'd1;
          end else begin
            state_d = ST_READ_DRIVE;
          end
        end

        ST_READ_HOLD: begin
          if (mode_s == MODE_READ) begin
            state_d = ST_READ_ACCESS;
            addr_d  = addr;
            cnt_d   = 8'd1;
          end else if (cnt_q >= HOLD_LIM) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end

        ST_WRITE_ACTIVE: begin
          if (mode_s == MODE_WRITE) begin
            cnt_d   = cnt_inc_s;
            wdata_d = dq;
            lb_n_d  = lb_n;
            ub_n_d  = ub_n;
          end else if (cnt_q >= WP_LIM) begin
            state_d     = ST_IDLE;
            mem_wr_en_s = 1'b1;
            wr_cnt_d    = wr_cnt_q + 16'd1;
          end else begin
            state_d = ST_IDLE;
            viol_d  = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched pin values, counters and busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      cnt_q     <= 8'd0;
      lb_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      wdata_q   <= 16'h0000;
      viol_q    <= 1'b0;
      rd_cnt_q  <= 16'h0000;
      wr_cnt_q  <= 16'h0000;
      rd_busy_q <= 1'b0;
      wr_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      lb_n_q    <= lb_n_d;
      ub_n_q    <= ub_n_d;
      wdata_q   <= wdata_d;
      viol_q    <= viol_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_busy_q <= (state_d == ST_READ_ACCESS) || (state_d == ST_READ_DRIVE) ||
                   (state_d == ST_READ_HOLD);
      wr_busy_q <= (state_d == ST_WRITE_ACTIVE);
    end
  end

  // Array is addressed by the latched address for both fetch and commit;
  // the two never coincide because read and write states are exclusive.
  sram_byte_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .addr_i  (addr_q[DEPTH_LOG2-1:0]),
    .rd_en_i (mem_rd_en_s && !rst),
    .wr_en_i (mem_wr_en_s && !rst),
    .be_i    ({~ub_n_q, ~lb_n_q}),
    .wdata_i (wdata_q),
    .rdata_o (rdata_s)
  );

  // Lane enables are taken live from the pins while driving.
  assign drive_s     = (state_q == ST_READ_DRIVE) || (state_q == ST_READ_HOLD);
  assign dq[7:0]     = (drive_s && !lb_n) ? rdata_s[7:0]  : 8'hzz;
  assign dq[15:8]    = (drive_s && !ub_n) ? rdata_s[15:8] : 8'hzz;

  assign read_busy       = rd_busy_q;
  assign write_busy      = wr_busy_q;
  assign write_violation = viol_q;
  assign read_count      = rd_cnt_q;
  assign write_count     = wr_cnt_q;

endmodule

// File: tb/tb_sram_device_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_device_responder
// Scoreboard bench: each read pushes its expected word when launched and pops
// it when the data phase arrives. dq carries pull-ups so a released bus reads
// as all ones.
// -----------------------------------------------------------------------------
module tb_sram_device_responder;
  import sram_pkg::*;

  localparam int ACC  = 10;
  localparam int HOLD = 2;
  localparam int WP   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  wire  [15:0] dq;
  logic        read_busy, write_busy, write_violation;
  logic [15:0] read_count, write_count;

  assign dq = tb_dq_en ? tb_dq : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end

  always #5 clk = ~clk;

  sram_device_responder #(
    .ADDR_W(18), .DEPTH_LOG2(12), .ACCESS_CYCLES(ACC),
    .HOLD_CYCLES(HOLD), .WRITE_PULSE_CYCLES(WP)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .dq(dq),
    .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .lb_n(lb_n), .ub_n(ub_n),
    .read_busy(read_busy), .write_busy(write_busy),
    .write_violation(write_violation),
    .read_count(read_count), .write_count(write_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] model [int];
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic        exp_viol = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_ctrl(input logic [4:0] ctrl, input logic [17:0] a);
    {ce_n, oe_n, we_n, lb_n, ub_n} = ctrl;
    addr = a;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_rdcnt"}, 32'(read_count), 32'(exp_rd[15:0]));
    check_eq({tag, "_wrcnt"}, 32'(write_count), 32'(exp_wr[15:0]));
    check_eq({tag, "_viol"}, 32'(write_violation), 32'(exp_viol));
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input logic wlb_n, input logic wub_n, input int n);
    int          idx;
    logic [15:0] w;
    idx = int'(a[11:0]);
    set_ctrl(CTRL_WRITE | {3'b000, wlb_n, wub_n}, a);
    tb_dq    = d;
    tb_dq_en = 1'b1;
    repeat (n) cyc();
    check_eq("wr_busy", 32'(write_busy), 32'd1);
    set_ctrl(CTRL_IDLE, a);
    tb_dq_en = 1'b0;
    cyc();
    check_eq("wr_done", 32'(write_busy), 32'd0);
    if (n >= WP) begin
      w = model.exists(idx) ? model[idx] : 16'h0000;
      if (!wlb_n) w[7:0]  = d[7:0];
      if (!wub_n) w[15:8] = d[15:8];
      model[idx] = w;
      exp_wr++;
    end else begin
      exp_viol = 1'b1;
    end
    check_status("wr");
  endtask

  // Launch a read, check the bus stays released through the access time,
  // then pop the expected word and compare. Leaves the read pins asserted.
  task automatic do_read(input logic [17:0] a, input logic rlb_n, input logic rub_n,
                         output logic [15:0] seen);
    logic [15:0] d;
    d = model[int'(a[11:0])];
    exp_q.push_back({rub_n ? 8'hFF : d[15:8], rlb_n ? 8'hFF : d[7:0]});
    set_ctrl(CTRL_READ | {3'b000, rlb_n, rub_n}, a);
    for (int i = 1; i <= ACC; i++) begin
      cyc();
      check_eq("acc_z", 32'(dq), 32'h0000FFFF);
    end
    cyc();
    exp_rd++;
    check_eq("rd_busy", 32'(read_busy), 32'd1);
    check_eq("sb_size", 32'(exp_q.size()), 32'd1);
    seen = exp_q.pop_front();
    check_eq("rd_data", 32'(dq), 32'(seen));
    check_status("rd");
  endtask

  // Deselect via ce_n only (lanes stay enabled) and check the hold window.
  task automatic end_read(input logic [15:0] last);
    ce_n = 1'b1;
    for (int i = 1; i <= HOLD; i++) begin
      cyc();
      check_eq("hold_drv", 32'(dq), 32'(last));
    end
    cyc();
    check_eq("hold_end_z", 32'(dq), 32'h0000FFFF);
    check_eq("hold_end_busy", 32'(read_busy), 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    rst      = 1'b1;
    tb_dq    = 16'h0000;
    tb_dq_en = 1'b0;
    set_ctrl(CTRL_IDLE, 18'h00000);
    repeat (2) cyc();
    check_eq("rst_rbusy", 32'(read_busy), 32'd0);
    check_eq("rst_wbusy", 32'(write_busy), 32'd0);
    check_eq("rst_dq_z", 32'(dq), 32'h0000FFFF);
    check_status("rst");
    rst = 1'b0;
    cyc();

    // Preload
    do_write(18'h00005, 16'hBEEF, 1'b0, 1'b0, WP);
    do_write(18'h00010, 16'h5566, 1'b0, 1'b0, WP);
    do_write(18'h00020, 16'h2020, 1'b0, 1'b0, WP);
    do_write(18'h00001, 16'h1111, 1'b0, 1'b0, WP);
    do_write(18'h00002, 16'h2222, 1'b0, 1'b0, WP + 2);
    do_write(18'h00030, 16'h3030, 1'b0, 1'b0, WP);

    // Basic read with hold after deselect
    do_read(18'h00005, 1'b0, 1'b0, v);
    end_read(v);

    // Lower-lane-only write, then read with live lane enables
    do_write(18'h00010, 16'h1234, 1'b0, 1'b1, WP);
    do_read(18'h00010, 1'b0, 1'b1, v);
    ub_n = 1'b0;
    cyc();
    check_eq("lane_live", 32'(dq), 32'h00005534);
    end_read(16'h5534);

    // Short write: no commit, sticky violation
    do_write(18'h00020, 16'h7777, 1'b0, 1'b0, 3);
    do_read(18'h00020, 1'b0, 1'b0, v);
    end_read(v);
    check_eq("viol_sticky", 32'(write_violation), 32'd1);

    // Read interrupted by an address change after 6 cycles
    set_ctrl(CTRL_READ, 18'h00001);
    repeat (6) begin
      cyc();
      check_eq("intr_z", 32'(dq), 32'h0000FFFF);
    end
    do_read(18'h00002, 1'b0, 1'b0, v);
    end_read(v);

    // Upper address bits alias onto the implemented depth
    do_read(18'h01005, 1'b0, 1'b0, v);
    end_read(v);

    // Reset in the middle of a write pulse
    set_ctrl(CTRL_WRITE, 18'h00030);
    tb_dq    = 16'h9999;
    tb_dq_en = 1'b1;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_ctrl(CTRL_IDLE, 18'h00030);
    tb_dq_en = 1'b0;
    exp_rd   = 0;
    exp_wr   = 0;
    exp_viol = 1'b0;
    cyc();
    check_eq("mrst_wbusy", 32'(write_busy), 32'd0);
    check_eq("mrst_dq_z", 32'(dq), 32'h0000FFFF);
    check_status("mrst");
    do_read(18'h00030, 1'b0, 1'b0, v);
    end_read(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
